pixel_writer: RTL and testbench

- Downstream consumer of buffer_2. Takes one 32-bit pixel word at a time from buffer_2 (o_buffer2_data / o_write_enable) and writes it to output-image memory over a simple request/ready write port.
- Generates sequential word addresses from a base and pulses o_write_complete back to buffer_2 so it advances to the next pixel.
- Tracks a pixel count per frame, flags frame completion, and flags memory timeouts.

---
 rtl/pixel_writer_pkg.sv | 16 +
 rtl/pixel_writer.sv | 103 ++++++++++
 tb/tb_pixel_writer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_writer_pkg.sv
// Shared types and default constants for the output-image pixel writer.
package pixel_writer_pkg;

  localparam int          PIXEL_W             = 32;
  localparam logic [31:0] DEF_BASE_ADDR       = 32'h0001_0000;
  localparam logic [31:0] DEF_ADDR_STEP       = 32'd4;
  localparam int          DEF_PIXEL_COUNT     = 307200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_writer.sv
// Drains pixel words from buffer_2 into output-image memory at sequential
// addresses, counting pixels per frame and flagging write timeouts.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [31:0] ADDR_STEP   = DEF_ADDR_STEP,
  parameter int          PIXEL_COUNT = DEF_PIXEL_COUNT,
  parameter int          CNT_W       = 19,
  parameter int          TIMEOUT     = 64
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               i_start,
  input  logic               i_write_enable,
  input  logic [PIXEL_W-1:0] i_buffer2_data,
  output logic               o_write_complete,
  output logic [31:0]        o_mem_addr,
  output logic [PIXEL_W-1:0] o_mem_wdata,
  output logic               o_mem_write,
  input  logic               i_mem_ready,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_error
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIXEL_COUNT - 1);

  state_t             state;
  logic [CNT_W-1:0]   pix_cnt;
  logic [TMO_W-1:0]   tmo_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= IDLE;
      pix_cnt          <= '0;
      tmo_cnt          <= '0;
      o_write_complete <= 1'b0;
      o_mem_addr       <= BASE_ADDR;
      o_mem_wdata      <= '0;
      o_mem_write      <= 1'b0;
      o_busy           <= 1'b0;
      o_frame_done     <= 1'b0;
      o_error          <= 1'b0;
    end else begin
      o_write_complete <= 1'b0;
      case (state)
        IDLE: begin
          // A start request always wins over a pending pixel in the same cycle.
          if (i_start) begin
            o_mem_addr   <= BASE_ADDR;
            pix_cnt      <= '0;
            o_frame_done <= 1'b0;
            o_error      <= 1'b0;
          end else if (i_write_enable && !o_frame_done) begin
            o_mem_wdata <= i_buffer2_data;
            o_mem_write <= 1'b1;
            tmo_cnt     <= '0;
            o_busy      <= 1'b1;
            state       <= WRITE;
          end
        end

        WRITE: begin
          if (i_mem_ready) begin
            o_mem_write <= 1'b0;
            state       <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abandon without completing; the same pixel is retried later.
            o_mem_write <= 1'b0;
            o_error     <= 1'b1;
            o_busy      <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        DONE: begin
          o_write_complete <= 1'b1;
          o_mem_addr       <= o_mem_addr + ADDR_STEP;
          pix_cnt          <= pix_cnt + 1'b1;
          if (pix_cnt == CNT_LAST) o_frame_done <= 1'b1;
          state            <= GAP;
        end

        GAP: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          o_mem_write <= 1'b0;
          o_busy      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Bench for pixel_writer: directed scenarios plus randomized pixels scored
// against a transaction-level model of address, count and sticky flags.
module tb_pixel_writer;

  localparam int          TMO  = 8;
  localparam int          PC   = 4;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_start;
  logic        i_write_enable;
  logic [31:0] i_buffer2_data;
  logic        o_write_complete;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_write;
  logic        i_mem_ready;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_error;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_addr;
  int          m_cnt;
  bit          m_err;
  bit          m_done;

  pixel_writer #(
    .BASE_ADDR  (BASE),
    .ADDR_STEP  (32'd4),
    .PIXEL_COUNT(PC),
    .CNT_W      (19),
    .TIMEOUT    (TMO)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .i_start         (i_start),
    .i_write_enable  (i_write_enable),
    .i_buffer2_data  (i_buffer2_data),
    .o_write_complete(o_write_complete),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wdata     (o_mem_wdata),
    .o_mem_write     (o_mem_write),
    .i_mem_ready     (i_mem_ready),
    .o_busy          (o_busy),
    .o_frame_done    (o_frame_done),
    .o_error         (o_error)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_addr = BASE;
    m_cnt  = 0;
    m_err  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    model_reset();
  endtask

  // Offer one pixel; memory holds ready low for d write cycles, then high.
  task automatic do_pixel(input logic [31:0] data, input int d);
    int wcnt, ccnt, cpos, exp_w, exp_c;
    bit bad;
    wcnt = 0; ccnt = 0; cpos = -1; bad = 1'b0;
    @(negedge clk);
    i_write_enable = 1'b1;
    i_buffer2_data = data;
    i_mem_ready    = 1'b0;
    for (int k = 1; k <= TMO + 8; k++) begin
      @(negedge clk);
      i_write_enable = 1'b0;
      if (o_mem_write) begin
        wcnt++;
        if (o_mem_addr !== m_addr || o_mem_wdata !== data) bad = 1'b1;
      end
      if (o_write_complete) begin
        ccnt++;
        cpos = k;
      end
      i_mem_ready = o_mem_write && (wcnt > d);
    end
    i_mem_ready = 1'b0;
    if (m_done) begin
      exp_w = 0; exp_c = 0;
    end else if (d < TMO) begin
      exp_w = d + 1; exp_c = 1;
    end else begin
      exp_w = TMO; exp_c = 0;
    end
    check("write_cycles", wcnt, exp_w);
    check("complete_pulses", ccnt, exp_c);
    if (exp_c == 1) check("complete_latency", cpos, d + 3);
    check("addr_data_stable", 32'(bad), 32'd0);
    if (!m_done) begin
      if (d < TMO) begin
        m_addr = m_addr + 32'd4;
        m_cnt++;
        if (m_cnt == PC) m_done = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    check("addr_after", o_mem_addr, m_addr);
    check("error_flag", 32'(o_error), 32'(m_err));
    check("frame_done", 32'(o_frame_done), 32'(m_done));
    check("busy_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [31:0] pix [4];
    logic [31:0] dcol;
    int wn, cc, d;

    n_rst = 1'b0; i_start = 1'b0; i_write_enable = 1'b0;
    i_buffer2_data = '0; i_mem_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_write", 32'(o_mem_write), 32'd0);
    check("rst_addr", o_mem_addr, BASE);
    check("rst_wdata", o_mem_wdata, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    n_rst = 1'b1;

    // Single write, back-pressure, timeout, retry at the same address
    do_start();
    do_pixel(32'h0C0C_0C00, 0);
    do_pixel($urandom, 5);
    do_pixel($urandom, TMO + 3);
    do_pixel($urandom, 0);

    // Reset asserted mid-write
    @(negedge clk);
    i_write_enable = 1'b1; i_buffer2_data = 32'hDEAD_BE00; i_mem_ready = 1'b0;
    @(negedge clk);
    i_write_enable = 1'b0;
    @(negedge clk);
    check("pre_rst_write", 32'(o_mem_write), 32'd1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_write", 32'(o_mem_write), 32'd0);
    check("mid_rst_complete", 32'(o_write_complete), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_addr", o_mem_addr, BASE);
    check("mid_rst_done", 32'(o_frame_done), 32'd0);
    check("mid_rst_error", 32'(o_error), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    model_reset();

    // Randomized pixels, delays and occasional restarts
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 9) == 0) do_start();
      if ($urandom_range(0, 4) == 0) d = int'($urandom_range(TMO, TMO + 4));
      else d = int'($urandom_range(0, TMO - 1));
      do_pixel($urandom, d);
    end

    // Start and write-enable together: start wins, write follows at BASE
    do_start();
    do_pixel($urandom, TMO + 2);
    do_pixel($urandom, 0);
    dcol = $urandom;
    @(negedge clk);
    i_start = 1'b1; i_write_enable = 1'b1; i_buffer2_data = dcol;
    @(negedge clk);
    i_start = 1'b0;
    check("coll_write", 32'(o_mem_write), 32'd0);
    check("coll_addr", o_mem_addr, BASE);
    check("coll_error", 32'(o_error), 32'd0);
    model_reset();
    @(negedge clk);
    i_write_enable = 1'b0; i_mem_ready = 1'b1;
    check("coll_wr_active", 32'(o_mem_write), 32'd1);
    check("coll_wr_addr", o_mem_addr, BASE);
    check("coll_wr_data", o_mem_wdata, dcol);
    @(negedge clk);
    i_mem_ready = 1'b0;
    @(negedge clk);
    check("coll_complete", 32'(o_write_complete), 32'd1);
    check("coll_next_addr", o_mem_addr, BASE + 32'd4);
    repeat (2) @(negedge clk);

    // Full frame with write-enable held high throughout
    do_start();
    for (int i = 0; i < 4; i++) pix[i] = $urandom;
    wn = 0; cc = 0;
    @(negedge clk);
    i_write_enable = 1'b1; i_buffer2_data = pix[0]; i_mem_ready = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (o_mem_write) begin
        if (wn < 4) begin
          check("frame_addr", o_mem_addr, BASE + 32'(4 * wn));
          check("frame_data", o_mem_wdata, pix[wn]);
        end
        wn++;
      end
      if (o_write_complete) begin
        cc++;
        if (cc < 4) i_buffer2_data = pix[cc];
      end
    end
    i_write_enable = 1'b0; i_mem_ready = 1'b0;
    check("frame_writes", wn, 32'd4);
    check("frame_completes", cc, 32'd4);
    check("frame_done_set", 32'(o_frame_done), 32'd1);
    check("frame_addr_end", o_mem_addr, BASE + 32'd16);
    m_addr = BASE + 32'd16; m_cnt = PC; m_done = 1'b1; m_err = 1'b0;
    do_pixel($urandom, 0);

    do_start();
    @(negedge clk);
    check("start_clr_done", 32'(o_frame_done), 32'd0);
    check("start_clr_error", 32'(o_error), 32'd0);
    check("start_clr_addr", o_mem_addr, BASE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
